// File: rtl/dpi_pkt_sequencer.sv
// dpi_pkt_sequencer: sequences packet bytes into stateful category matchers.
// Ports: clk/rst_n clock and async active-low reset; pkt_* upstream beat
// stream with pkt_rdy handshake; cfg_enable/cfg_flush configuration;
// load_state/new_stream_id/stream_id/enable matcher context; char_in/
// char_in_vld byte stream; eop commit pulse; pkt_count/drop_count statistics.
module dpi_pkt_sequencer #(
  parameter int NUM_CAT   = 8,
  parameter int EOP_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_vld,
  input  logic               pkt_sop,
  input  logic               pkt_eop,
  input  logic [7:0]         pkt_data,
  input  logic [15:0]        pkt_flow_tag,
  output logic               pkt_rdy,
  input  logic [NUM_CAT-1:0] cfg_enable,
  input  logic               cfg_flush,
  output logic               load_state,
  output logic               new_stream_id,
  output logic [5:0]         stream_id,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               eop,
  output logic [NUM_CAT-1:0] enable,
  output logic [15:0]        pkt_count,
  output logic [15:0]        drop_count
);
  localparam int CW = $clog2(EOP_DELAY + 2);
  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] valid_q, valid_d;
  logic [15:0] tag_q [64];
  logic [15:0] tag_d [64];
  logic [5:0] alloc_q, alloc_d, sid_q, sid_d, hit_idx;
  logic new_q, new_d, hit, miss, accept, sop_take, in_stream;
  logic [15:0] flow_q, flow_d, pcnt_q, pcnt_d, dcnt_q, dcnt_d;
  logic [NUM_CAT-1:0] en_q, en_d;
  logic [7:0] char_q, char_d;
  logic cvld_q, cvld_d;
  assign accept    = pkt_vld && pkt_rdy;
  assign sop_take  = state_q == IDLE && pkt_vld && pkt_sop;
  assign miss      = state_q == LOOKUP && !hit;
  // the held sop beat is consumed in GAP so its byte lands two cycles after load_state
  assign in_stream = state_q == GAP || state_q == STREAM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < 64; i++) tag_q[i] <= '0;
      alloc_q <= '0;
      sid_q   <= '0;
      new_q   <= 1'b0;
      flow_q  <= '0;
      en_q    <= '0;
      char_q  <= '0;
      cvld_q  <= 1'b0;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      alloc_q <= alloc_d;
      sid_q   <= sid_d;
      new_q   <= new_d;
      flow_q  <= flow_d;
      en_q    <= en_d;
      char_q  <= char_d;
      cvld_q  <= cvld_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = sop_take ? LOOKUP : IDLE;
      LOOKUP:      state_d = LOAD;
      LOAD:        state_d = GAP;
      GAP, STREAM: state_d = (accept && pkt_eop) ? DRAIN : STREAM;
      DRAIN:       state_d = (cnt_q == CW'(EOP_DELAY)) ? EOP : DRAIN;
      EOP:         state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end
  always_comb begin
    pkt_rdy    = (state_q == IDLE) ? (pkt_vld && !pkt_sop) : in_stream;
    load_state = state_q == LOAD;
    eop        = state_q == EOP;
  end
  // descending scan leaves the lowest matching index
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == flow_q) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
    end
  end
  // a flush coinciding with a miss still keeps the fresh allocation
  always_comb begin
    valid_d = cfg_flush ? '0 : valid_q;
    tag_d   = tag_q;
    if (miss) begin
      valid_d[alloc_q] = 1'b1;
      tag_d[alloc_q]   = flow_q;
    end
    alloc_d = miss ? alloc_q + 6'd1 : (cfg_flush ? '0 : alloc_q);
    flow_d  = sop_take ? pkt_flow_tag : flow_q;
    en_d    = sop_take ? cfg_enable : en_q;
    sid_d   = (state_q == LOOKUP) ? (hit ? hit_idx : alloc_q) : sid_q;
    new_d   = (state_q == LOOKUP) ? !hit : new_q;
    cvld_d  = accept && in_stream;
    char_d  = cvld_d ? pkt_data : char_q;
    cnt_d   = (state_q == DRAIN) ? cnt_q + 1'b1 : '0;
    pcnt_d  = (state_q == EOP && pcnt_q != 16'hFFFF) ? pcnt_q + 16'd1 : pcnt_q;
    dcnt_d  = (state_q == IDLE && pkt_vld && !pkt_sop && dcnt_q != 16'hFFFF) ? dcnt_q + 16'd1 : dcnt_q;
  end
  assign new_stream_id = new_q;
  assign stream_id     = sid_q;
  assign char_in       = char_q;
  assign char_in_vld   = cvld_q;
  assign enable        = en_q;
  assign pkt_count     = pcnt_q;
  assign drop_count    = dcnt_q;
endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// tb_dpi_pkt_sequencer: directed vector table plus hand-written corner sequences.
module tb_dpi_pkt_sequencer;
  localparam int EOP_DELAY = 4;
  logic clk = 0, rst_n = 1;
  logic pkt_vld = 0, pkt_sop = 0, pkt_eop = 0, cfg_flush = 0;
  logic [7:0] pkt_data = 0, cfg_enable = 0;
  logic [15:0] pkt_flow_tag = 0;
  logic pkt_rdy, load_state, new_stream_id, char_in_vld, eop;
  logic [5:0] stream_id;
  logic [7:0] char_in, enable;
  logic [15:0] pkt_count, drop_count;
  dpi_pkt_sequencer #(.NUM_CAT(8), .EOP_DELAY(EOP_DELAY)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_data(pkt_data), .pkt_flow_tag(pkt_flow_tag), .pkt_rdy(pkt_rdy),
    .cfg_enable(cfg_enable), .cfg_flush(cfg_flush), .load_state(load_state),
    .new_stream_id(new_stream_id), .stream_id(stream_id), .char_in(char_in),
    .char_in_vld(char_in_vld), .eop(eop), .enable(enable), .pkt_count(pkt_count),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  int pass_cnt = 0, tot_cnt = 0, exp_pc = 0;
  int cyc = 0, load_cnt = 0, eop_cnt = 0, load_cyc = 0, eop_cyc = 0, viol = 0;
  logic [5:0] ls_sid = 0, eop_sid = 0;
  logic ls_new = 0, prev_load = 0;
  logic [7:0] ls_en = 0;
  logic [7:0] cv[$];
  int cc[$];
  always @(negedge clk) begin
    cyc++;
    if (load_state) begin
      load_cnt++;
      ls_sid = stream_id;
      ls_new = new_stream_id;
      ls_en = enable;
      load_cyc = cyc;
    end
    if (char_in_vld) begin
      cv.push_back(char_in);
      cc.push_back(cyc);
    end
    if (eop) begin
      eop_cnt++;
      eop_cyc = cyc;
      eop_sid = stream_id;
    end
    if ((load_state && eop) || (char_in_vld && (load_state || eop || prev_load))) viol++;
    prev_load = load_state;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    pkt_vld = 0;
    repeat (2) step();
    rst_n = 1;
    exp_pc = 0;
  endtask
  task automatic send_pkt(input logic [15:0] tag, input int n, input int bub, input logic [7:0] en, input logic flush_lk);
    int i, j, e0;
    bit bubbled, acc;
    i = 0;
    j = 0;
    e0 = eop_cnt;
    bubbled = 0;
    while (i < n && j < 60) begin
      cfg_flush = flush_lk && j == 1;
      if (!bubbled && i == bub && i > 0) begin
        pkt_vld = 0;
        bubbled = 1;
      end else begin
        pkt_vld = 1;
        pkt_sop = (i == 0);
        pkt_eop = (i == n - 1);
        pkt_data = 8'hA0 + 8'(i);
        pkt_flow_tag = tag;
        cfg_enable = en;
      end
      @(negedge clk);
      acc = pkt_vld && pkt_rdy;
      @(posedge clk);
      #1;
      if (acc) i++;
      j++;
    end
    pkt_vld = 0;
    pkt_sop = 0;
    pkt_eop = 0;
    cfg_flush = 0;
    chk("beats_accepted", i, n);
    for (int k = 0; k < 40 && eop_cnt == e0; k++) @(posedge clk);
    chk("eop_seen", eop_cnt - e0, 1);
    #1;
  endtask
  task automatic run_vec(input logic [15:0] tag, input int n, input int bub, input logic [7:0] en,
                         input logic [5:0] sid, input logic nw, input logic flush_lk);
    int l0;
    bit ok;
    l0 = load_cnt;
    cv.delete();
    cc.delete();
    send_pkt(tag, n, bub, en, flush_lk);
    exp_pc++;
    chk("load_pulses", load_cnt - l0, 1);
    chk("stream_id", ls_sid, sid);
    chk("new_stream_id", ls_new, nw);
    chk("enable", ls_en, en);
    chk("char_count", cv.size(), n);
    ok = 1;
    foreach (cv[k]) if (cv[k] !== 8'hA0 + 8'(k)) ok = 0;
    chk("char_data", ok, 1);
    if (cc.size() == n) begin
      chk("first_char_lat", cc[0] - load_cyc, 2);
      chk("eop_after_last", eop_cyc - cc[n-1], EOP_DELAY + 1);
      if (bub > 0) chk("bubble_gap", cc[bub] - cc[bub-1], 2);
    end
    chk("eop_stream_id", eop_sid, sid);
    chk("pkt_count", pkt_count, exp_pc);
  endtask
  typedef struct {
    logic [15:0] tag;
    int n;
    int bub;
    logic [7:0] en;
    logic [5:0] sid;
    logic nw;
  } vec_t;
  vec_t vt[6];
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int l0;
    vt[0] = '{16'h1234, 3, -1, 8'hFF, 6'd0, 1'b1};
    vt[1] = '{16'h5678, 1, -1, 8'h0F, 6'd1, 1'b1};
    vt[2] = '{16'h1234, 2,  1, 8'h81, 6'd0, 1'b0};
    vt[3] = '{16'h5678, 4,  2, 8'h3C, 6'd1, 1'b0};
    vt[4] = '{16'h9ABC, 5, -1, 8'h00, 6'd2, 1'b1};
    vt[5] = '{16'h9ABC, 3,  1, 8'h55, 6'd2, 1'b0};
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {pkt_rdy, load_state, new_stream_id, char_in_vld, eop}, 0);
    chk("rst_ids", {stream_id, char_in, enable}, 0);
    chk("rst_counts", {pkt_count, drop_count}, 0);
    step();
    rst_n = 1;
    step();
    l0 = load_cnt;
    for (int k = 0; k < 3; k++) begin
      pkt_vld = 1;
      pkt_sop = 0;
      pkt_data = 8'(k);
      @(negedge clk);
      chk("drop_rdy", pkt_rdy, 1);
      step();
    end
    pkt_vld = 0;
    @(negedge clk);
    chk("drop_count", drop_count, 3);
    chk("drop_no_load", load_cnt - l0, 0);
    step();
    foreach (vt[v]) run_vec(vt[v].tag, vt[v].n, vt[v].bub, vt[v].en, vt[v].sid, vt[v].nw, 1'b0);
    chk("no_overlap", viol, 0);
    l0 = eop_cnt;
    pkt_vld = 1;
    pkt_sop = 1;
    pkt_eop = 0;
    pkt_flow_tag = 16'h7777;
    pkt_data = 8'h11;
    repeat (4) step();
    pkt_sop = 0;
    pkt_data = 8'h22;
    step();
    rst_n = 0;
    pkt_vld = 0;
    @(negedge clk);
    chk("midrst_ctrl", {pkt_rdy, load_state, new_stream_id, char_in_vld, eop}, 0);
    chk("midrst_ids", {stream_id, char_in, enable}, 0);
    chk("midrst_counts", {pkt_count, drop_count}, 0);
    step();
    rst_n = 1;
    exp_pc = 0;
    repeat (20) step();
    chk("midrst_no_eop", eop_cnt - l0, 0);
    for (int k = 0; k < 65; k++) run_vec(16'h1000 + 16'(k), 1, -1, 8'h01, 6'(k % 64), 1'b1, 1'b0);
    run_vec(16'h1000, 1, -1, 8'h02, 6'd1, 1'b1, 1'b0);
    do_reset();
    step();
    run_vec(16'hAAAA, 2, -1, 8'hC3, 6'd0, 1'b1, 1'b1);
    run_vec(16'hAAAA, 2, -1, 8'hC3, 6'd0, 1'b0, 1'b0);
    run_vec(16'h5555, 1, -1, 8'h3C, 6'd1, 1'b1, 1'b0);
    cfg_flush = 1;
    step();
    cfg_flush = 0;
    run_vec(16'h5555, 1, -1, 8'h3C, 6'd0, 1'b1, 1'b0);
    chk("no_overlap_end", viol, 0);
    pkt_vld = 1;
    pkt_sop = 0;
    repeat (65540) step();
    @(negedge clk);
    chk("drop_saturate", drop_count, 16'hFFFF);
    pkt_vld = 0;
    step();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/dpi_pkt_sequencer.md
DPI_PKT_SEQUENCER -- requirements
Module: dpi_pkt_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; all flops SHALL clear on rst_n low, independent of clk.
REQ-002 The block SHALL have these parameters:
- NUM_CAT, default 8: number of category matchers driven.
- EOP_DELAY, default 4: idle cycles between the last char_in_vld and eop, covering matcher pipeline drain.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- pkt_vld  in  1  packet beat valid
- pkt_sop  in  1  first beat of packet
- pkt_eop  in  1  last beat of packet
- pkt_data  in  8  payload byte
- pkt_flow_tag  in  16  flow identifier, valid on sop beat
- pkt_rdy  out  1  beat accepted when pkt_vld and pkt_rdy both high
- cfg_enable  in  NUM_CAT  per-category enable, sampled at sop
- cfg_flush  in  1  pulse: invalidate flow table
- load_state  out  1  one-cycle pulse: matchers restore state
- new_stream_id  out  1  qualifies load_state: stream unseen, reset state
- stream_id  out  6  matcher state-memory index
- char_in  out  8  byte to matchers
- char_in_vld  out  1  char_in valid
- eop  out  1  one-cycle pulse: matchers commit count/state
- enable  out  NUM_CAT  latched cfg_enable, held from LOAD through EOP
- pkt_count  out  16  packets sequenced, saturating
- drop_count  out  16  orphan beats dropped, saturating

Function
REQ-004 The block SHALL implement the FSM IDLE -> LOOKUP -> LOAD -> GAP -> STREAM -> DRAIN -> EOP -> IDLE.
REQ-005 IDLE: pkt_rdy SHALL be 1 only when pkt_vld=1 and pkt_sop=0; such beats SHALL be discarded and drop_count SHALL increment. A beat with pkt_vld=1 and pkt_sop=1 SHALL NOT be consumed; it SHALL move the FSM to LOOKUP and latch pkt_flow_tag and cfg_enable.
REQ-006 The flow table SHALL hold 64 entries of {valid, tag[15:0]}.
REQ-007 LOOKUP (1 cycle), tag hit: stream_id SHALL be set to the lowest matching index and new_stream_id to 0.
REQ-008 LOOKUP, tag miss: the entry at alloc_ptr SHALL be overwritten with valid=1 and the tag; stream_id SHALL be set to alloc_ptr, new_stream_id to 1, and alloc_ptr SHALL increment, wrapping 63 -> 0 (oldest replaced when full).
REQ-009 LOAD (1 cycle): load_state SHALL be 1; stream_id, new_stream_id and enable SHALL be stable from this cycle until EOP completes.
REQ-010 GAP (1 cycle): all matcher outputs SHALL be idle, so the first char_in_vld is at least 2 cycles after load_state.
REQ-011 STREAM: pkt_rdy SHALL equal 1.
- Each accepted beat, including the held sop beat, SHALL produce char_in = pkt_data with char_in_vld = 1 on the following cycle.
- Cycles with no accepted beat SHALL give char_in_vld = 0.
- The accepted beat with pkt_eop = 1 SHALL move the FSM to DRAIN.
REQ-012 STREAM: a beat with pkt_sop=1 other than the first SHALL be treated as a data byte (no restart).
REQ-013 DRAIN: pkt_rdy SHALL be 0 and the FSM SHALL remain for exactly EOP_DELAY cycles after the last char_in_vld.
REQ-014 EOP (1 cycle): eop SHALL be 1, pkt_count SHALL increment, and the next state SHALL be IDLE.
REQ-015 A single-beat packet (sop=eop) SHALL follow the full sequence and produce exactly one char_in_vld.
REQ-016 Both counters SHALL saturate at 16'hFFFF.
REQ-017 cfg_flush SHALL clear all valid bits and alloc_ptr on the next edge. If the flush coincides with LOOKUP, the lookup SHALL use pre-flush contents and the allocation SHALL survive the flush.
REQ-018 load_state and eop SHALL never be high in the same cycle, and char_in_vld SHALL never be high during LOAD, GAP or EOP.

Reset
REQ-019 On reset, the FSM SHALL go to IDLE and the following SHALL be 0: all valid bits, alloc_ptr, pkt_rdy, load_state, new_stream_id, stream_id, char_in, char_in_vld, eop, enable, and both counters.
REQ-020 Reset asserted mid-packet SHALL abort the packet with no eop pulse; the upstream SHALL restart from sop.

Verification
REQ-021 Fresh tag 0x1234, 3-byte packet -> load_state at T with new_stream_id=1 and stream_id=0; char_in_vld at T+2..T+4; eop at T+9; pkt_count=1.
REQ-022 Second packet with tag 0x1234 after one with 0x5678 -> load_state with new_stream_id=0 and stream_id=0; the 0x5678 packet gets stream_id=1.
REQ-023 65 distinct tags -> the 65th gets stream_id=0 with new_stream_id=1; tag #1 afterwards misses and allocates stream_id=1.
REQ-024 Non-sop beats in IDLE (3 beats) -> pkt_rdy=1 for each, drop_count=3, no load_state.
REQ-025 Upstream pkt_vld bubbles in STREAM -> char_in_vld gaps match the bubbles; the eop timing rule of REQ-013 holds from the last byte.
REQ-026 cfg_flush in the same cycle as LOOKUP for tag 0xAAAA -> stream_id=0 with new_stream_id=1; the next 0xAAAA packet hits index 0.
